output_uart_tx: RTL and testbench

- Downstream consumer of the CPU output register path.
- Each time the CPU asserts outputWrite, the 16-bit output word is captured into a small FIFO.
- Each word is serialized over a UART TX line as two 8N1 bytes, high byte first, so program output reaches a host terminal.
- Decouples single-cycle CPU output writes from the slow serial line; sits between the datapath output and the board TX pin.

---
 rtl/output_uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_output_uart_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_uart_tx.sv
// output_uart_tx
// Buffers 16-bit words written by the CPU output path in a small FIFO and
// sends each one on a UART TX line as two 8N1 bytes: high byte first, and
// LSB first within each byte.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high
//   data_in     word to enqueue
//   outputWrite push strobe; each cycle it is high is one push
//   tx          serial line, idles high
//   busy        FIFO non-empty or a frame in flight
//   full        FIFO holds FIFO_DEPTH words
//   overflow    sticky; a push was dropped because the FIFO was full
//   fifo_count  words waiting in the FIFO (the word being sent is not counted)
//
// state | meaning
// IDLE  | line high; pops the head word when the FIFO is non-empty
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high); after the high byte, start the low byte with no gap
module output_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [15:0]                 data_in,
  input  logic                        outputWrite,
  output logic                        tx,
  output logic                        busy,
  output logic                        full,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            byte_hi_q, byte_hi_d;
  logic [7:0]      shift_q, shift_d;
  // Only the low byte needs holding: the high byte goes straight to shift_q.
  logic [7:0]      hold_lo_q, hold_lo_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic push, pop, baud_last, fifo_full;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_hi_d  = byte_hi_q;
    shift_d    = shift_q;
    hold_lo_d  = hold_lo_q;
    overflow_d = overflow_q;
    pop        = 1'b0;
    baud_last  = (baud_q == BAUD_LAST);
    fifo_full  = (count_q == CNT_FULL);

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q][15:8];
          hold_lo_d = mem_q[rd_ptr_q][7:0];
          byte_hi_d = 1'b1;
          baud_d    = '0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d    = '0;
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (byte_hi_q) begin
            shift_d   = hold_lo_q;
            byte_hi_d = 1'b0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A concurrent pop frees a slot, so a full FIFO still accepts the push.
    push = outputWrite && (!fifo_full || pop);
    if (outputWrite && fifo_full && !pop) overflow_d = 1'b1;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // tx and busy are decoded from next state so they are glitch-free flops.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_hi_q  <= 1'b1;
      shift_q    <= 8'h00;
      hold_lo_q  <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_hi_q  <= byte_hi_d;
      shift_q    <= shift_d;
      hold_lo_q  <= hold_lo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: reset clears the pointers, which discards contents.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;
  assign full       = (count_q == CNT_FULL);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_output_uart_tx.sv
`timescale 1ns/1ps
module tb_output_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic        wr;
  logic        tx, busy, full, overflow;
  logic [2:0]  fifo_count;

  logic [15:0] d_din;
  logic        d_wr;
  logic        d_tx, d_busy, d_full, d_ovf;
  logic [2:0]  d_cnt;

  always #5 clock = ~clock;

  output_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(rst), .data_in(din), .outputWrite(wr),
    .tx(tx), .busy(busy), .full(full), .overflow(overflow), .fifo_count(fifo_count));

  output_uart_tx u_dflt (
    .clock(clock), .reset(rst), .data_in(d_din), .outputWrite(d_wr),
    .tx(d_tx), .busy(d_busy), .full(d_full), .overflow(d_ovf), .fifo_count(d_cnt));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // cycle counter and UART receiver watching the main DUT
  int          cyc = 0;
  logic [7:0]  rx_bytes[$];
  int          rx_starts[$];
  int          frame_err = 0;
  bit          rx_act = 0;
  int          rx_n = 0;
  logic [7:0]  rx_sh;
  logic [15:0] exp_w[$];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (rst) begin
      rx_act = 0;
      rx_n   = 0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1;
        rx_n   = 0;
        rx_starts.push_back(cyc);
      end
    end else begin
      rx_n++;
      if (rx_n % CPB == 2 && rx_n / CPB >= 1 && rx_n / CPB <= 8)
        rx_sh[rx_n / CPB - 1] = tx;
      if (rx_n == CPB * 9 + 2) begin
        if (tx !== 1'b1) frame_err++;
        rx_bytes.push_back(rx_sh);
        rx_act = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    wr  = 1'b1;
    din = w;
    tick();
    wr  = 1'b0;
  endtask

  task automatic clear_rx();
    rx_bytes.delete();
    rx_starts.delete();
    frame_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    clear_rx();
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, busy, 0);
    repeat (3) tick();
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_nbytes"}, rx_bytes.size(), exp_w.size() * 2);
    chk({tag, "_frame_err"}, frame_err, 0);
    for (int i = 0; i < exp_w.size(); i++) begin
      if (2 * i + 1 < rx_bytes.size()) begin
        chk({tag, "_hi"}, rx_bytes[2*i],   exp_w[i][15:8]);
        chk({tag, "_lo"}, rx_bytes[2*i+1], exp_w[i][7:0]);
      end
    end
  endtask

  logic [15:0] w1;
  logic        bits[20];
  logic [7:0]  bb;
  int          n, m;

  initial begin
    rst = 1'b1; wr = 1'b0; din = 16'h0; d_wr = 1'b0; d_din = 16'h0;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_dflt_tx", d_tx, 1);
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_rx();

    // Test 1: single word, bit-exact waveform
    w1 = 16'h41A5;
    for (int k = 0; k < 2; k++) begin
      bb = (k == 0) ? w1[15:8] : w1[7:0];
      bits[k*10] = 1'b0;
      for (int i = 0; i < 8; i++) bits[k*10+1+i] = bb[i];
      bits[k*10+9] = 1'b1;
    end
    push_word(w1);
    chk("t1_cnt_push", fifo_count, 1);
    chk("t1_tx_push", tx, 1);
    chk("t1_busy_push", busy, 1);
    tick();
    chk("t1_cnt_pop", fifo_count, 0);
    for (int b = 0; b < 20; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk("t1_bit", tx, bits[b]);
        chk("t1_busy", busy, 1);
        tick();
      end
    end
    chk("t1_busy_fall", busy, 0);
    chk("t1_tx_idle", tx, 1);
    tick(); tick();
    exp_w = {16'h41A5};
    check_words("t1");

    // Test 2: back-to-back pushes
    do_reset();
    push_word(16'h1234);
    push_word(16'h5678);
    chk("t2_cnt1", fifo_count, 1);
    push_word(16'h9ABC);
    chk("t2_cnt_peak", fifo_count, 2);
    wait_idle("t2", 3 * 81 + 50);
    exp_w = {16'h1234, 16'h5678, 16'h9ABC};
    check_words("t2");
    chk("t2_nstarts", rx_starts.size(), 6);
    for (int i = 1; i < rx_starts.size(); i++)
      chk("t2_gap", rx_starts[i] - rx_starts[i-1], (i % 2 == 1) ? 10*CPB : 10*CPB + 1);
    chk("t2_ovf", overflow, 0);

    // Test 3: overflow
    do_reset();
    push_word(16'h0101);
    chk("t3_cnt1", fifo_count, 1);
    push_word(16'h0202);
    chk("t3_cnt2", fifo_count, 1);
    push_word(16'h0303);
    chk("t3_cnt3", fifo_count, 2);
    push_word(16'h0404);
    chk("t3_cnt4", fifo_count, 3);
    push_word(16'h0505);
    chk("t3_cnt5", fifo_count, 4);
    chk("t3_full", full, 1);
    chk("t3_ovf_pre", overflow, 0);
    push_word(16'h0606);
    chk("t3_cnt6", fifo_count, 4);
    chk("t3_ovf_set", overflow, 1);
    wait_idle("t3", 5 * 81 + 50);
    chk("t3_ovf_sticky", overflow, 1);
    exp_w = {16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
    check_words("t3");

    // Test 4: push on the exact edge IDLE pops while full
    do_reset();
    chk("t4_ovf_cleared", overflow, 0);
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    push_word(16'h4444);
    push_word(16'h5555);
    chk("t4_full", full, 1);
    repeat (77) tick();
    chk("t4_cnt_prepop", fifo_count, 4);
    push_word(16'h6666);
    chk("t4_cnt_pushpop", fifo_count, 4);
    chk("t4_full_after", full, 1);
    chk("t4_ovf", overflow, 0);
    wait_idle("t4", 6 * 81 + 50);
    chk("t4_ovf_end", overflow, 0);
    exp_w = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    check_words("t4");

    // Test 5: reset during DATA bit 3 of the first byte
    do_reset();
    push_word(16'hA55A);
    push_word(16'h1111);
    push_word(16'h2222);
    chk("t5_cnt_queued", fifo_count, 2);
    repeat (16) tick();
    chk("t5_pre_tx", tx, 0);
    rst = 1'b1;
    #1;
    chk("t5_tx_async", tx, 1);
    chk("t5_cnt", fifo_count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ovf", overflow, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_rx();
    repeat (60) tick();
    chk("t5_no_bytes", rx_bytes.size(), 0);
    chk("t5_tx_quiet", tx, 1);
    chk("t5_busy_quiet", busy, 0);
    push_word(16'h00FF);
    wait_idle("t5", 81 + 50);
    exp_w = {16'h00FF};
    check_words("t5");

    // Test 6: default CLKS_PER_BIT timing
    d_wr = 1'b1;
    d_din = 16'hFFFF;
    tick();
    d_wr = 1'b0;
    tick();
    chk("t6_start_low", d_tx, 0);
    n = 0;
    while (d_tx == 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    chk("t6_start_len", n, 434);
    m = n;
    while (d_busy && m < 20000) begin
      tick();
      m++;
    end
    chk("t6_word_len", m, 8680);
    chk("t6_tx_end", d_tx, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
